// File: rtl/clk_div_pkg.sv
// Shared constants and types for the clk_div_bank clock divider family.
package clk_div_pkg;

    // Width of the channel-index field on the config port.
    localparam int CH_W = 4;

    // A half-period of zero parks a channel (output held low).
    localparam int unsigned DIV_PARKED = 0;

    // Reset half-period: 1 Hz output from a 100 MHz system clock.
    localparam int unsigned DEFAULT_DIV = 50_000_000;

    // Decoded per-channel operating mode.
    typedef enum logic [1:0] {
        CH_OFF,
        CH_PARKED,
        CH_RUN
    } chan_mode_e;

endpackage

// File: rtl/clk_div_bank_if.sv
// Config port of clk_div_bank: write strobe, target channel, divisor and
// the registered acknowledge/error response.
interface clk_div_bank_if
    import clk_div_pkg::*;
#(
    parameter int W = 32
) ();

    logic            cfg_we;
    logic [CH_W-1:0] cfg_ch;
    logic [W-1:0]    cfg_div;
    logic            cfg_ack;
    logic            cfg_err;

    modport master (
        output cfg_we,
        output cfg_ch,
        output cfg_div,
        input  cfg_ack,
        input  cfg_err
    );

    modport slave (
        input  cfg_we,
        input  cfg_ch,
        input  cfg_div,
        output cfg_ack,
        output cfg_err
    );

endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: 50%-duty divided clock, rise tick, and a pending
// divisor that is only adopted at a toggle boundary (or on sync).
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int          W           = 32,
    parameter int unsigned DEFAULT_DIV = clk_div_pkg::DEFAULT_DIV
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    input  logic         sync_i,
    input  logic         wr_i,
    input  logic [W-1:0] wr_div_i,
    output logic         clk_out_o,
    output logic         tick_o,
    output logic         pend_o
);

    localparam logic [W-1:0] DIV_RST = W'(DEFAULT_DIV);
    localparam logic [W-1:0] PARKED  = W'(DIV_PARKED);

    chan_mode_e   mode;
    logic         boundary;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] div_act_q, div_act_d;
    logic [W-1:0] div_pend_q, div_pend_d;
    logic         pend_q, pend_d;
    logic         clk_q, clk_d;
    logic         tick_q, tick_d;

    // Decode the operating mode and detect the end of a half-period.
    always_comb begin
        if (!en_i) begin
            mode = CH_OFF;
        end else if (div_act_q == PARKED) begin
            mode = CH_PARKED;
        end else begin
            mode = CH_RUN;
        end
        boundary = (mode == CH_RUN) && (cnt_q == div_act_q - W'(1));
    end

    // Next-state logic for counter, divisors and outputs.
    always_comb begin
        cnt_d      = cnt_q;
        div_act_d  = div_act_q;
        div_pend_d = div_pend_q;
        pend_d     = pend_q;
        clk_d      = clk_q;
        tick_d     = 1'b0;

        case (mode)
            CH_RUN: begin
                if (sync_i) begin
                    cnt_d = '0;
                    clk_d = 1'b0;
                    if (pend_q) begin
                        div_act_d = div_pend_q;
                        pend_d    = 1'b0;
                    end
                end else if (boundary) begin
                    cnt_d = '0;
                    if (pend_q) begin
                        div_act_d = div_pend_q;
                        pend_d    = 1'b0;
                    end
                    // Adopting a parked divisor must not leave a stray high
                    // half-cycle, so the output is forced low instead.
                    if (pend_q && (div_pend_q == PARKED)) begin
                        clk_d = 1'b0;
                    end else begin
                        clk_d  = ~clk_q;
                        tick_d = ~clk_q;
                    end
                end else begin
                    cnt_d = cnt_q + W'(1);
                end
                // A write in the same cycle as a boundary or sync always
                // lands in the pending slot for the following boundary.
                if (wr_i) begin
                    div_pend_d = wr_div_i;
                    pend_d     = 1'b1;
                end
            end
            default: begin
                // Disabled or parked: output idle, divisor loads directly.
                cnt_d = '0;
                clk_d = 1'b0;
                if (wr_i) begin
                    div_act_d = wr_div_i;
                    pend_d    = 1'b0;
                end
            end
        endcase
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            div_act_q  <= DIV_RST;
            div_pend_q <= '0;
            pend_q     <= 1'b0;
            clk_q      <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            div_act_q  <= div_act_d;
            div_pend_q <= div_pend_d;
            pend_q     <= pend_d;
            clk_q      <= clk_d;
            tick_q     <= tick_d;
        end
    end

    assign clk_out_o = clk_q;
    assign tick_o    = tick_q;
    assign pend_o    = pend_q;

endmodule

// File: rtl/clk_div_bank.sv
// Multi-channel programmable clock divider: config decode, registered
// ack/err response and sync fan-out around NCH divider channels.
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int          NCH         = 4,
    parameter int          W           = 32,
    parameter int unsigned DEFAULT_DIV = clk_div_pkg::DEFAULT_DIV
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NCH-1:0]  en,
    input  logic            sync,
    clk_div_bank_if.slave   cfg,
    output logic [NCH-1:0]  clk_out,
    output logic [NCH-1:0]  tick,
    output logic [NCH-1:0]  pend
);

    logic cfg_ack_q, cfg_ack_d;
    logic cfg_err_q, cfg_err_d;

    // Every write is acknowledged; out-of-range channels flag an error.
    always_comb begin
        cfg_ack_d = cfg.cfg_we;
        cfg_err_d = cfg.cfg_we && (int'(cfg.cfg_ch) >= NCH);
    end

    // Config response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_ack_q <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            cfg_ack_q <= cfg_ack_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign cfg.cfg_ack = cfg_ack_q;
    assign cfg.cfg_err = cfg_err_q;

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        logic wr;

        // Channel select; an out-of-range index matches no channel.
        always_comb begin
            wr = cfg.cfg_we && (cfg.cfg_ch == CH_W'(i));
        end

        clk_div_chan #(
            .W           (W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .en_i      (en[i]),
            .sync_i    (sync),
            .wr_i      (wr),
            .wr_div_i  (cfg.cfg_div),
            .clk_out_o (clk_out[i]),
            .tick_o    (tick[i]),
            .pend_o    (pend[i])
        );
    end

endmodule

// File: doc/clk_div_bank.md
Name: clk_div_bank

Overview:
- Multi-channel programmable clock divider for FPGA board designs, e.g. display scan, debounce sampling and slow CPU single-step clocks.
- Each of NCH channels produces a 50%-duty divided clock plus a one-cycle tick strobe.
- The half-period is reprogrammable at run time through a simple config port.
- A new divisor takes effect only at a toggle boundary, so reconfiguration never produces a glitch.

Parameters:
- NCH, 4, number of independent channels (1..16).
- W, 32, divisor/counter width in bits.
- DEFAULT_DIV, 50_000_000, half-period (in clk cycles) loaded into every channel at reset (1 Hz from 100 MHz).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  NCH  per-channel run enable.
- sync  in  1  one-cycle pulse; realigns the phase of all channels.
- cfg_we  in  1  config write strobe.
- cfg_ch  in  4  target channel index.
- cfg_div  in  W  new half-period; 0 = channel parked.
- cfg_ack  out  1  one-cycle acknowledge, asserted the cycle after cfg_we.
- cfg_err  out  1  valid with cfg_ack; 1 if cfg_ch >= NCH.
- clk_out  out  NCH  divided clocks, registered.
- tick  out  NCH  one-cycle strobe in the same cycle clk_out[i] rises.
- pend  out  NCH  1 while a written divisor awaits its boundary.

Behaviour:
- Reset (async assert, sync release):
  - clk_out, tick, pend, cfg_ack, cfg_err = 0.
  - All counters = 0.
  - div_act[i] = DEFAULT_DIV.
- Per-channel state: cnt (W), div_act (W), div_pend (W), pend flag, clk_out, tick.
- Running (en[i]=1, div_act!=0):
  - cnt increments every cycle.
  - When cnt == div_act-1: cnt<=0 and clk_out toggles. This is the boundary.
  - Output period = 2*div_act cycles, duty exactly 50%.
  - The first rise comes div_act cycles after en rises.
- tick[i]=1 only in the cycle clk_out[i] goes 0->1.
- Parked (div_act==0): clk_out=0, tick=0, cnt=0.
- Disabled (en[i]=0): cnt<=0, clk_out<=0 on the next edge, tick=0. div_act, div_pend and pend are retained.
- Config write (cfg_we=1, cfg_ch<NCH):
  - If the channel is running: div_pend<=cfg_div, pend<=1.
  - At the next boundary: div_act<=div_pend, pend<=0.
  - If the channel is disabled or parked: div_act<=cfg_div directly, cnt<=0, pend stays 0.
  - A second write before the boundary overwrites div_pend (last write wins).
- Config write with cfg_ch>=NCH: no state change; cfg_err=1 together with cfg_ack.
- Write in the same cycle as a boundary: the boundary applies the previously pending value, if any. The new write becomes pending (pend=1) for the following boundary.
- sync=1: every running channel gets cnt<=0 and clk_out<=0, and any pending divisor is applied immediately (pend<=0).
  - Priority: sync beats the normal count/toggle.
  - A cfg_we in the same cycle as sync is still captured, as pending.
- Arithmetic: compare against div_act-1 computed in W bits. div_act=1 gives clk_out toggling every cycle (clk/2).
- Reset mid-operation: all outputs drop immediately and asynchronously; programmed divisors are lost (back to DEFAULT_DIV).

Decomposition:
- Shared package/include clk_div_pkg holds:
  - the channel-index width constant (4);
  - the parked encoding (0);
  - the DEFAULT_DIV localparam, so other blocks derive rates from the same value.
- One sub-module, clk_div_chan:
  - single channel with W and DEFAULT_DIV parameters;
  - instantiated NCH times via generate;
  - the top level holds config decode, cfg_ack/cfg_err registers and the sync fan-out.

Test Plan:
- Reset release with en=4'b0001, DEFAULT_DIV overridden to 3 -> clk_out[0] rises 3 cycles after en, period 6, tick[0] one cycle per period, other channels stay 0.
- Running ch0 div=3; write cfg_ch=0 cfg_div=5 mid half-period -> pend[0]=1 until next toggle; after it, half-periods are 5; no half-period shorter than 3.
- Two writes (7, then 2) before the boundary -> only 2 applied; cfg_ack pulses twice, cfg_err=0.
- cfg_ch=9 with NCH=4 -> cfg_ack=1 and cfg_err=1 next cycle; all div_act unchanged.
- ch0 div=2, ch1 div=3 running; pulse sync -> both clk_out=0 next cycle; both rise together 2/3 cycles later respectively; a simultaneous cfg_we to ch1 leaves pend[1]=1.
- Write cfg_div=0 to a running channel -> after the boundary clk_out holds 0, tick silent; write 1 while parked -> clk_out toggles every cycle immediately after.
